// File: rtl/rbm_input_loader.sv
// Serial-to-parallel frame loader feeding the RBM: assembles input_dim words, holds data_valid until finish.
// Optional double buffering (shadow frame filled during COMPUTE) is enabled by defining RBM_LOADER_DBUF_EN.
module rbm_input_loader #(
  parameter int bitlength = 12,
  parameter int input_dim = 4,
  parameter int cnt_width = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [bitlength-1:0]           word_in,
  input  logic                           word_valid,
  output logic                           word_ready,
  input  logic                           finish,
  output logic                           data_valid,
  output logic [input_dim*bitlength-1:0] InputDataPort,
  output logic [cnt_width-1:0]           frame_count,
  output logic                           busy,
  output logic [1:0]                     fsm_state
);

  // Handshake: a word transfers on a rising clock edge where word_valid && word_ready;
  // word_valid may drop at any time and the word index simply holds.

  localparam int IW = (input_dim > 1) ? $clog2(input_dim) : 1;
  localparam logic [IW-1:0] LAST = IW'(input_dim - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx;
  logic          finish_d;
  logic          finish_edge;
  logic          take;
  logic          last_take;

  assign finish_edge = finish & ~finish_d;
  assign take        = word_valid & word_ready;
  assign last_take   = take && (idx == LAST);
  assign data_valid  = (state == COMPUTE);
  assign busy        = (state == COMPUTE) || (state == RELEASE);
  assign fsm_state   = state;

`ifdef RBM_LOADER_DBUF_EN
  logic [input_dim*bitlength-1:0] shadow, shadow_next;
  logic                           shadow_full;
  logic                           rearm;

  // Refusing words on the finish edge keeps a completing shadow from racing the frame swap.
  assign word_ready = (state == FILL) ||
                      ((state == COMPUTE) && !shadow_full && !finish_edge);

  always_comb begin
    shadow_next = shadow;
    if (take) shadow_next[idx*bitlength +: bitlength] = word_in;
  end
`else
  assign word_ready = (state == FILL);
`endif

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (last_take) state_next = COMPUTE;
      COMPUTE: if (finish_edge) state_next = RELEASE;
`ifdef RBM_LOADER_DBUF_EN
      RELEASE: state_next = rearm ? COMPUTE : FILL;
`else
      RELEASE: state_next = FILL;
`endif
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= FILL;
      idx           <= '0;
      finish_d      <= 1'b0;
      frame_count   <= '0;
      InputDataPort <= '0;
`ifdef RBM_LOADER_DBUF_EN
      shadow        <= '0;
      shadow_full   <= 1'b0;
      rearm         <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      finish_d <= finish;
      if (take) idx <= (idx == LAST) ? '0 : idx + 1'b1;
      if ((state == COMPUTE) && finish_edge) frame_count <= frame_count + 1'b1;
`ifdef RBM_LOADER_DBUF_EN
      shadow <= shadow_next;
      if ((state == FILL) && last_take) InputDataPort <= shadow_next;
      if ((state == COMPUTE) && last_take) shadow_full <= 1'b1;
      if ((state == COMPUTE) && finish_edge && shadow_full) begin
        InputDataPort <= shadow;
        shadow_full   <= 1'b0;
        rearm         <= 1'b1;
      end
      if (state == RELEASE) rearm <= 1'b0;
`else
      if (take) InputDataPort[idx*bitlength +: bitlength] <= word_in;
`endif
    end
  end

endmodule
